// File: rtl/booth8_ctrl.sv
// Sequencing controller for a radix-8 Booth multiplier datapath.
// Captures operands on start, clears the datapath, loads M then Q over the
// shared data bus, and then runs ITER recode/add/shift iterations. Each
// iteration uses the datapath's Q[2:0]/Qm1 feedback. A done pulse marks the end.
module booth8_ctrl #(
  parameter int W    = 15,
  parameter int ITER = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] mplier,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         dp_rst,
  output logic [W-1:0] data_out,
  output logic         ldM,
  output logic         ldQ,
  output logic         ldA,
  output logic         addsub,
  output logic [1:0]   Num,
  output logic         shift,
  input  logic [2:0]   q0,
  input  logic         qm1,
  input  logic         zero
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDM, S_LDQ, S_EVAL, S_ADD, S_SHIFT, S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic signed [3:0]  digit;
  logic signed [3:0]  d_eval;
  logic [W-1:0]       mcand_r;
  logic [W-1:0]       mplier_r;

  // Booth digit -4*q[2] + 2*q[1] + q[0] + qm1, range -4..+4
  function automatic logic signed [3:0] booth_digit(input logic [2:0] q, input logic m);
    logic signed [3:0] v;
    v = 4'sd0;
    if (q[2]) v = v - 4'sd4;
    if (q[1]) v = v + 4'sd2;
    if (q[0]) v = v + 4'sd1;
    if (m)    v = v + 4'sd1;
    return v;
  endfunction

  // Magnitude select code: |d| = 1,2,3,4 -> 01,10,11,00
  function automatic logic [1:0] num_sel(input logic signed [3:0] d);
    logic [3:0] mag;
    mag = d[3] ? 4'(-d) : 4'(d);
    case (mag)
      4'd1:    return 2'b01;
      4'd2:    return 2'b10;
      4'd3:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  assign d_eval = booth_digit(q0, qm1);

  // Add/subtract and multiple select decode from state and the registered digit
  assign addsub = (state == S_ADD) && !digit[3];
  assign Num    = (state == S_ADD) ? num_sel(digit) : 2'b00;

  // Operand capture on an accepted start; held for the whole operation
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      mcand_r  <= mcand;
      mplier_r <= mplier;
    end
  end

  // Main sequencer; pulse outputs are registered alongside the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      digit    <= 4'sd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      dp_rst   <= 1'b0;
      ldM      <= 1'b0;
      ldQ      <= 1'b0;
      ldA      <= 1'b0;
      shift    <= 1'b0;
      data_out <= '0;
    end else begin
      dp_rst   <= 1'b0;
      ldM      <= 1'b0;
      ldQ      <= 1'b0;
      ldA      <= 1'b0;
      shift    <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err    <= 1'b0;
            cnt    <= CW'(ITER);
            busy   <= 1'b1;
            dp_rst <= 1'b1;
            state  <= S_CLR;
          end
        end
        S_CLR: begin
          ldM      <= 1'b1;
          data_out <= mcand_r;
          state    <= S_LDM;
        end
        S_LDM: begin
          ldQ      <= 1'b1;
          data_out <= mplier_r;
          state    <= S_LDQ;
        end
        S_LDQ: state <= S_EVAL;
        S_EVAL: begin
          digit <= d_eval;
          if (zero) begin
            // Iteration count exhausted before the last digit: abort
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (d_eval != 4'sd0) begin
            ldA   <= 1'b1;
            state <= S_ADD;
          end else begin
            shift <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_ADD: begin
          shift <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_EVAL;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth8_ctrl.sv
// Bench for booth8_ctrl: a behavioural datapath stand-in plus a per-cycle
// expected-output schedule built from the multiplier's Booth digits.
module tb_booth8_ctrl;
  localparam int W    = 15;
  localparam int ITER = 5;
  localparam int AW   = W + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] mcand, mplier;
  logic         busy, done, err, dp_rst, ldM, ldQ, ldA, addsub, shift;
  logic [W-1:0] data_out;
  logic [1:0]   Num;
  logic [2:0]   q0;
  logic         qm1, zero;

  always #5 clk = ~clk;

  booth8_ctrl #(.W(W), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .err(err), .dp_rst(dp_rst), .data_out(data_out),
    .ldM(ldM), .ldQ(ldQ), .ldA(ldA), .addsub(addsub), .Num(Num), .shift(shift),
    .q0(q0), .qm1(qm1), .zero(zero)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic cmp_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, $signed(act), $signed(expv));
    end
  endtask

  // ---------------- datapath stand-in ----------------
  logic signed [AW-1:0]  dp_a = '0;
  logic signed [AW-1:0]  dp_m = '0;
  logic [W-1:0]          dp_q = '0;
  logic                  dp_qm1 = 1'b0;
  int                    dp_cnt = 0;
  int                    abort_iter = -1;
  logic signed [2*W-1:0] dp_prod;

  function automatic logic signed [AW-1:0] pp(input logic [1:0] n, input logic signed [AW-1:0] m);
    case (n)
      2'b01:   return m;
      2'b10:   return m <<< 1;
      2'b11:   return m + (m <<< 1);
      default: return m <<< 2;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dp_rst) begin
      dp_a <= '0; dp_q <= '0; dp_qm1 <= 1'b0; dp_cnt <= 0;
    end else begin
      if (ldM) dp_m <= AW'($signed(data_out));
      if (ldQ) begin dp_q <= data_out; dp_qm1 <= 1'b0; dp_cnt <= ITER; end
      if (ldA) dp_a <= addsub ? dp_a + pp(Num, dp_m) : dp_a - pp(Num, dp_m);
      if (shift) begin
        dp_a   <= dp_a >>> 3;
        dp_q   <= {dp_a[2:0], dp_q[W-1:3]};
        dp_qm1 <= dp_q[2];
        dp_cnt <= dp_cnt - 1;
      end
    end
  end

  assign q0      = dp_q[2:0];
  assign qm1     = dp_qm1;
  assign zero    = (dp_cnt == 0) || (abort_iter >= 0 && (ITER - dp_cnt) == abort_iter);
  assign dp_prod = {dp_a[W-1:0], dp_q};

  // ---------------- expected-output schedule ----------------
  typedef struct {
    logic         busy, done, err, dp_rst, ldM, ldQ, ldA, shift, addsub;
    logic [1:0]   num;
    logic [W-1:0] data;
  } exp_t;

  exp_t sched[$];
  exp_t exp_now;
  logic model_err;

  function automatic exp_t blank(input logic b, input logic e);
    exp_t x;
    x.busy = b; x.done = 1'b0; x.err = e; x.dp_rst = 1'b0; x.ldM = 1'b0;
    x.ldQ = 1'b0; x.ldA = 1'b0; x.shift = 1'b0; x.addsub = 1'b0;
    x.num = 2'b00; x.data = '0;
    return x;
  endfunction

  // Booth digit i of the multiplier: bits 3i+2, 3i+1, 3i and 3i-1 (0 below bit 0)
  function automatic int bdig(input logic [W-1:0] mp, input int i);
    int bm;
    bm = 0;
    if (i > 0) bm = int'(mp[3*i-1]);
    return -4 * int'(mp[3*i+2]) + 2 * int'(mp[3*i+1]) + int'(mp[3*i]) + bm;
  endfunction

  function automatic int total_cycles(input logic [W-1:0] mp);
    int t;
    t = 4;
    for (int i = 0; i < ITER; i++) t += (bdig(mp, i) != 0) ? 3 : 2;
    return t;
  endfunction

  function automatic void build(input logic [W-1:0] mc, input logic [W-1:0] mp, input int ab);
    exp_t e;
    int   d;
    e = blank(1'b1, 1'b0); e.dp_rst = 1'b1; sched.push_back(e);
    e = blank(1'b1, 1'b0); e.ldM = 1'b1; e.data = mc; sched.push_back(e);
    e = blank(1'b1, 1'b0); e.ldQ = 1'b1; e.data = mp; sched.push_back(e);
    for (int i = 0; i < ITER; i++) begin
      sched.push_back(blank(1'b1, 1'b0));
      if (i == ab) begin
        e = blank(1'b1, 1'b1); e.done = 1'b1; sched.push_back(e);
        sched.push_back(blank(1'b0, 1'b1));
        return;
      end
      d = bdig(mp, i);
      if (d != 0) begin
        e = blank(1'b1, 1'b0); e.ldA = 1'b1; e.addsub = (d > 0);
        e.num = ((d == 4) || (d == -4)) ? 2'b00 : 2'((d < 0) ? -d : d);
        sched.push_back(e);
      end
      e = blank(1'b1, 1'b0); e.shift = 1'b1; sched.push_back(e);
    end
    e = blank(1'b1, 1'b0); e.done = 1'b1; sched.push_back(e);
    sched.push_back(blank(1'b0, 1'b0));
  endfunction

  // Schedule advance: an empty schedule means the controller is idle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      exp_now   <= blank(1'b0, 1'b0);
      model_err <= 1'b0;
    end else begin
      if (sched.size() == 0 && start) build(mcand, mplier, abort_iter);
      if (sched.size() > 0) begin
        exp_now   <= sched[0];
        model_err <= sched[0].err;
        void'(sched.pop_front());
      end else begin
        exp_now <= blank(1'b0, model_err);
      end
    end
  end

  // Per-cycle comparison against the schedule
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", 32'(busy), 32'(exp_now.busy));
      chk("done", 32'(done), 32'(exp_now.done));
      chk("err", 32'(err), 32'(exp_now.err));
      chk("dp_rst", 32'(dp_rst), 32'(exp_now.dp_rst));
      chk("ldM", 32'(ldM), 32'(exp_now.ldM));
      chk("ldQ", 32'(ldQ), 32'(exp_now.ldQ));
      chk("ldA", 32'(ldA), 32'(exp_now.ldA));
      chk("shift", 32'(shift), 32'(exp_now.shift));
      chk("data_out", 32'(data_out), 32'(exp_now.data));
      if (exp_now.ldA) begin
        chk("addsub", 32'(addsub), 32'(exp_now.addsub));
        chk("Num", 32'(Num), 32'(exp_now.num));
      end
    end
  end

  // ---------------- stimulus ----------------
  int   t0, done_k, dprst_k, nshift;
  logic err_at_done, err_k1, got_done;
  int   lda_k[$];
  logic lda_as[$];
  logic [1:0] lda_num[$];
  int   shift_k[$];

  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input int ab);
    int rel;
    logic signed [2*W-1:0] ep;
    lda_k.delete(); lda_as.delete(); lda_num.delete(); shift_k.delete();
    nshift = 0; done_k = -1; dprst_k = -1; got_done = 1'b0; err_k1 = 1'bx;
    abort_iter = ab;
    @(posedge clk); #1;
    mcand = mc; mplier = mp; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == 1) err_k1 = err;
      if (dp_rst) dprst_k = rel;
      if (ldA) begin lda_k.push_back(rel); lda_as.push_back(addsub); lda_num.push_back(Num); end
      if (shift) begin nshift++; shift_k.push_back(rel); end
      if (done) begin got_done = 1'b1; done_k = rel; err_at_done = err; end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("dp_rst_cycle", 32'(dprst_k), 32'd1);
    chk("err_cleared", 32'(err_k1), 32'd0);
    if (ab < 0) begin
      ep = $signed(mc) * $signed(mp);
      chk("product", 32'(dp_prod), 32'(ep));
      chk("done_cycle", 32'(done_k), 32'(total_cycles(mp)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    int ab;
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dp_rst", 32'(dp_rst), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_Num", 32'(Num), 32'd0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // 3 * 5: digits -3, +1, 0, 0, 0
    run_op(W'(3), W'(5), -1);
    chk("t1_lda_count", 32'(lda_k.size()), 32'd2);
    if (lda_k.size() == 2) begin
      chk("t1_add0_cycle", 32'(lda_k[0]), 32'd5);
      chk("t1_add0_addsub", 32'(lda_as[0]), 32'd0);
      chk("t1_add0_Num", 32'(lda_num[0]), 32'd3);
      chk("t1_add1_cycle", 32'(lda_k[1]), 32'd8);
      chk("t1_add1_addsub", 32'(lda_as[1]), 32'd1);
      chk("t1_add1_Num", 32'(lda_num[1]), 32'd1);
    end
    chk("t1_shift_count", 32'(shift_k.size()), 32'd5);
    if (shift_k.size() == 5) begin
      chk("t1_shift0", 32'(shift_k[0]), 32'd6);
      chk("t1_shift1", 32'(shift_k[1]), 32'd9);
      chk("t1_shift4", 32'(shift_k[4]), 32'd15);
    end
    chk("t1_done_cycle", 32'(done_k), 32'd16);
    chk("t1_product", 32'(dp_prod), 32'd15);

    // Multiplier 0: no accumulate, done at cycle 14
    run_op(W'(9), W'(0), -1);
    chk("t2_lda_count", 32'(lda_k.size()), 32'd0);
    chk("t2_shifts", 32'(nshift), 32'd5);
    chk("t2_done_cycle", 32'(done_k), 32'd14);

    // 28 * 11: digits -4, +4
    run_op(W'(11), W'(28), -1);
    chk("t3_lda_count", 32'(lda_k.size()), 32'd2);
    if (lda_k.size() == 2) begin
      chk("t3_add0_addsub", 32'(lda_as[0]), 32'd0);
      chk("t3_add0_Num", 32'(lda_num[0]), 32'd0);
      chk("t3_add1_addsub", 32'(lda_as[1]), 32'd1);
      chk("t3_add1_Num", 32'(lda_num[1]), 32'd0);
    end
    chk("t3_done_cycle", 32'(done_k), 32'd16);
    chk("t3_product", 32'(dp_prod), 32'd308);

    // Zero flag during the second EVAL aborts the operation
    run_op(W'(3), W'(5), 1);
    chk("t4_done_cycle", 32'(done_k), 32'd8);
    chk("t4_shifts", 32'(nshift), 32'd1);
    chk("t4_err", 32'(err_at_done), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", 32'(err), 32'd1);
    run_op(W'(3), W'(5), -1);
    chk("t4_err_next", 32'(err), 32'd0);

    // Start while busy is ignored; reset in cycle 8 kills the operation
    abort_iter = -1;
    @(posedge clk); #1;
    mcand = W'(6); mplier = W'(7); start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    mcand = W'(100); mplier = W'(200);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 8) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ldA", 32'(ldA), 32'd0);
    chk("t5_rst_shift", 32'(shift), 32'd0);
    chk("t5_rst_Num", 32'(Num), 32'd0);
    chk("t5_rst_addsub", 32'(addsub), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (25) begin @(negedge clk); if (done) nd++; end
    chk("t5_no_done", 32'(nd), 32'd0);

    // Back-to-back operations with signed operands
    run_op(W'(-7), W'(9), -1);
    chk("t6_product_a", 32'(dp_prod), 32'(-63));
    run_op(W'(100), W'(-3), -1);
    chk("t6_product_b", 32'(dp_prod), 32'(-300));

    // Randomized operands, occasional aborts and idle gaps
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ITER - 1)) : -1;
      run_op(W'($urandom), W'($urandom), ab);
      if (ab >= 0) chk("rand_abort_err", 32'(err_at_done), 32'd1);
    end
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth8_ctrl.md
Name: booth8_ctrl

Overview:
- Sequencing controller that sits directly upstream of the radix-8 Booth multiplier datapath and drives all of its control inputs.
- Latches the multiplicand and multiplier on a start request and clears the datapath.
- Loads M, then Q, over the datapath's shared data bus.
- Runs ITER recode/add/shift iterations from the datapath's Q0/Qm1 feedback, then signals completion.

Parameters:
W, 15, operand width (datapath register width)
ITER, 5, number of radix-8 iterations (W/3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
mcand  in  W  multiplicand, captured when start accepted
mplier  in  W  multiplier, captured when start accepted
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle completion pulse
err  out  1  sticky; set if datapath zero is seen early, cleared on next accepted start
dp_rst  out  1  datapath clear pulse, driven directly from a flop
data_out  out  W  datapath data_in bus
ldM  out  1  load M
ldQ  out  1  load Q
ldA  out  1  accumulate
addsub  out  1  1 = add, 0 = subtract
Num  out  2  magnitude select: 01 = M, 10 = 2M, 11 = 3M, 00 = 4M
shift  out  1  arithmetic shift A:Q right by 3
q0  in  3  datapath Q[2:0]
qm1  in  1  datapath Qm1
zero  in  1  datapath iteration-count-zero flag

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, done, err, dp_rst, ldM, ldQ, ldA, shift, addsub = 0.
  - Num = 00, data_out = 0.
  - Internal iteration counter = 0; digit register = 0.
- States: IDLE, CLR, LDM, LDQ, EVAL, ADD, SHIFT, DONE.
- IDLE:
  - If start = 1, capture mcand and mplier, clear err, load the iteration counter with ITER, go to CLR.
  - start = 0 in any other state is don't-care; start while busy is ignored.
- CLR: dp_rst = 1 for exactly this cycle, driven from a flop that is set on the IDLE->CLR edge. Next state LDM.
- LDM: ldM = 1, data_out = captured mcand. Next state LDQ.
- LDQ: ldQ = 1, data_out = captured mplier. Next state EVAL.
- data_out = 0 in all states other than LDM and LDQ.
- EVAL:
  - Register the Booth digit d = -4*q0[2] + 2*q0[1] + q0[0] + qm1, range -4..+4.
  - If zero = 1: set err, go to DONE (abort).
  - Else if d != 0: go to ADD.
  - Else: go to SHIFT.
- ADD:
  - ldA = 1.
  - addsub = 1 if d > 0, 0 if d < 0.
  - Num from |d|: 1 -> 01, 2 -> 10, 3 -> 11, 4 -> 00.
  - Next state SHIFT.
- SHIFT:
  - shift = 1; decrement the iteration counter.
  - If the counter was 1: go to DONE. Else: go to EVAL.
- DONE: done = 1 for one cycle. Next state IDLE.
- Cycle budget:
  - Zero digit: 2 cycles (EVAL, SHIFT). Nonzero digit: 3 cycles (EVAL, ADD, SHIFT).
  - Start accepted at cycle 0 -> done in cycle 3 + sum(iteration cycles) + 1.
  - Range is 14..19 cycles for ITER = 5.
- Mutual exclusion: ldA and shift are never asserted in the same cycle; ldM, ldQ, ldA, shift are one-hot-or-zero.
- Outputs are a combinational decode of the state register and digit register only; no input reaches an output combinationally.
- Reset mid-operation: all outputs return to reset values immediately and state goes to IDLE; no done pulse is produced.

Test Plan:
- mcand = 3, mplier = 5, start at cycle 0:
  - dp_rst in cycle 1, ldM with data_out = 3 in cycle 2, ldQ with data_out = 5 in cycle 3.
  - ADD in cycle 5 (addsub = 0, Num = 11); ADD in cycle 8 (addsub = 1, Num = 01).
  - shift in cycles 6, 9, 11, 13, 15; done in cycle 16; datapath product = 15.
- mplier = 0: ldA never asserted; five shift pulses; done in cycle 14.
- mplier = 28: first ADD addsub = 0, Num = 00 (-4M); second ADD addsub = 1, Num = 00 (+4M); done in cycle 16; product = 28*mcand.
- zero forced to 1 during the second EVAL: err = 1, DONE the next cycle, no further shift; next start clears err.
- start pulsed while busy: ignored, captured operands unchanged; rst asserted in cycle 8: all outputs 0 at once, state IDLE, no done.
- Back-to-back ops (-7 * 9, then 100 * -3), with start in the cycle after done: dp_rst precedes each load and both products are correct.
